// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   AddrWidth  : default byte-address width of the instruction memory
//   InstrWidth : default instruction width
//   PcInc      : fetch PC increment per instruction (bytes)
//   ifetch_state_e : sequencer states
//   ifetch_entry_t : fetch-queue entry {pc, instr} at the default widths
package ifetch_pkg;

  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned InstrWidth = 32;
  localparam int unsigned PcInc      = 4;

  typedef enum logic [1:0] {
    StRun,
    StHalted,
    StFault
  } ifetch_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]  pc;
    logic [InstrWidth-1:0] instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Small FIFO holding fetched {pc, instr} entries ahead of decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (caller guarantees !full || pop)
//   pop        : retire the head (caller guarantees !empty)
//   flush      : empty the queue; wins over push and pop
//   rdata      : head entry storage (registered, zero after reset)
//   full/empty : occupancy flags
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = ifetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the instruction memory
// combinationally at that PC, queues {pc, instr} and presents the queue head to
// decode over valid/ready. Supports redirect (flush + new PC) and halt.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned redirects enter a FAULT
// state (fetch stopped, fault=1) until an aligned redirect; when undefined the
// low two redirect bits are ignored and fault is tied 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_addr / imem_data : instruction memory address (= fetch PC) / read word
//   id_valid, id_ready    : decode handshake; id_instr/id_pc = queue head
//   redirect, redirect_pc : load new fetch PC and flush the queue
//   halt                  : suspend fetching (queue still drains)
//   fault                 : misaligned-redirect fault flag
module ifetch_controller
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AddrWidth,
  parameter int unsigned       INSTR_W  = InstrWidth,
  parameter int unsigned       QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               fault
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  ifetch_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic              push, pop, flush, full, empty;
  entry_t            wdata, head;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
  assign fault      = (state_q == StFault);
`else
  assign target     = redirect_pc & ~ADDR_W'(3);
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  assign pop       = id_valid && id_ready;
  assign imem_addr = pc_q;
  assign id_valid  = !empty;
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign wdata     = '{pc: pc_q, instr: imem_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      StRun: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = target;
          if (misaligned) state_d = StFault;
        end else if (halt) begin
          state_d = StHalted;
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_W'(PcInc);
        end
      end
      StHalted: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = target;
          if (misaligned) state_d = StFault;
        end else if (!halt) begin
          state_d = StRun;
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      StFault: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = target;
          if (!misaligned) state_d = StRun;
        end
      end
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifetch_queue #(
    .Depth   (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ifetch_controller.sv
// Directed bench for ifetch_controller with a 256-byte big-endian memory model.
// Memory bytes 0..7 = 12 34 56 78 9A BC DE F0; every other byte i holds value i.
module tb_ifetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        fault;

  logic [7:0]  mem [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_data = {mem[imem_addr], mem[imem_addr + 8'd1],
                      mem[imem_addr + 8'd2], mem[imem_addr + 8'd3]};

  ifetch_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fault       (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [7:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, 32'(id_pc), 32'(pc));
    chk({tag, "_instr"}, id_instr, instr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;

    rst_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
    step(); step();
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", 32'(id_pc), 32'h00);
    chk("rst_fault", 32'(fault), 32'd0);

    // Sequential fetch, id_ready high.
    rst_n = 1'b1; id_ready = 1'b1;
    step();
    head("seq0", 8'h00, 32'h12345678);
    chk("seq0_addr", 32'(imem_addr), 32'h04);
    step();
    head("seq1", 8'h04, 32'h9ABCDEF0);
    chk("seq1_addr", 32'(imem_addr), 32'h08);

    // Reset mid-operation, then back-pressure fills the queue.
    rst_n = 1'b0; id_ready = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h00);
    chk("mid_rst_pc", 32'(id_pc), 32'h00);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("full_addr", 32'(imem_addr), 32'h08);
    head("full_head", 8'h00, 32'h12345678);
    id_ready = 1'b1;
    step();
    head("drain1", 8'h04, 32'h9ABCDEF0);
    step();
    head("drain2", 8'h08, 32'h08090A0B);
    chk("drain2_addr", 32'(imem_addr), 32'h10);

    // Redirect to 0x40 with two entries queued.
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("rd40_flush", 32'(id_valid), 32'd0);
    chk("rd40_addr", 32'(imem_addr), 32'h40);
    step();
    head("rd40_head", 8'h40, 32'h40414243);
    step();
    head("rd40_next", 8'h44, 32'h44454647);

    // Redirect to 0xFC and wrap.
    redirect = 1'b1; redirect_pc = 8'hFC;
    step();
    redirect = 1'b0;
    chk("rdfc_flush", 32'(id_valid), 32'd0);
    step();
    head("wrap_fc", 8'hFC, 32'hFCFDFEFF);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    step();
    head("wrap_00", 8'h00, 32'h12345678);
    step();
    head("wrap_04", 8'h04, 32'h9ABCDEF0);

    // Fill the queue, then halt with id_ready high.
    id_ready = 1'b0;
    step();
    chk("hfill_addr", 32'(imem_addr), 32'h0C);
    halt = 1'b1; id_ready = 1'b1;
    step();
    head("halt_h1", 8'h08, 32'h08090A0B);
    step();
    chk("halt_h2_valid", 32'(id_valid), 32'd0);
    step(); step();
    chk("halt_h4_valid", 32'(id_valid), 32'd0);
    chk("halt_h4_addr", 32'(imem_addr), 32'h0C);
    halt = 1'b0;
    step();
    chk("resume_wait", 32'(id_valid), 32'd0);
    step();
    head("resume", 8'h0C, 32'h0C0D0E0F);

    // Misaligned redirect to 0x42, then aligned redirect to 0x44.
    redirect = 1'b1; redirect_pc = 8'h42;
    step();
    redirect = 1'b0;
    chk("mis_valid", 32'(id_valid), 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_addr", 32'(imem_addr), 32'h42);
    step();
    chk("mis_hold_valid", 32'(id_valid), 32'd0);
    chk("mis_hold_fault", 32'(fault), 32'd1);
`else
    chk("mis_fault", 32'(fault), 32'd0);
    chk("mis_addr", 32'(imem_addr), 32'h40);
    step();
    head("mis_head", 8'h40, 32'h40414243);
    chk("mis_hold_fault", 32'(fault), 32'd0);
`endif
    redirect = 1'b1; redirect_pc = 8'h44;
    step();
    redirect = 1'b0;
    chk("al_fault", 32'(fault), 32'd0);
    chk("al_valid", 32'(id_valid), 32'd0);
    step();
    head("al_head", 8'h44, 32'h44454647);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_controller.md
# ifetch_controller

Instruction-fetch sequencer for the PA-RISC pipeline. Owns the fetch PC, drives the byte address of the 256-byte big-endian instruction memory, and captures the returned 32-bit word. Buffers instructions in a small queue and hands them to decode over a valid/ready handshake, with redirect (branch/exception) and halt control. Sits between `instruction_memory` and the IF/ID stage.

## Interface
- `ADDR_W`, 8: byte-address width; the memory has 2^ADDR_W bytes.
- `INSTR_W`, 32: instruction width.
- `QDEPTH`, 2: fetch-queue entries (power of two, ≥2).
- `RESET_PC`, 8'h00: fetch PC after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  ADDR_W  byte address to the instruction memory; equals fetch PC.
- `imem_data`  in  INSTR_W  word read combinationally at `imem_addr`, valid in the same cycle.
- `id_valid`  out  1  queue head is valid.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_instr`  out  INSTR_W  head instruction.
- `id_pc`  out  ADDR_W  byte address of the head instruction.
- `redirect`  in  1  load a new fetch PC and flush the queue.
- `redirect_pc`  in  ADDR_W  new fetch PC.
- `halt`  in  1  suspend fetching while high; the queue still drains.
- `fault`  out  1  misaligned-redirect fault flag (see Configuration).

## Operation
- States: RUN, HALTED, FAULT. Reset enters RUN with fetch PC = `RESET_PC`.
- Push condition, RUN only: `!halt && !redirect && (!full || pop)`. On a push, {fetch PC, `imem_data`} is written into the queue and fetch PC += 4, wrapping modulo 2^ADDR_W (252 → 0).
- Pop: `id_valid && id_ready`. Push and pop in the same cycle are allowed when full; occupancy is unchanged.
- `id_valid` = queue not empty. `id_instr`/`id_pc` come from queue-head storage; no combinational path from `imem_data` to `id_*`.
- Redirect has the highest priority. The queue is flushed, fetch PC ← target, and there is no push that cycle. A pop in the same cycle is discarded: the entry is lost, and decode must treat it as squashed.
- RUN → HALTED when `halt=1` and `redirect=0`. HALTED → RUN when `halt=0`. A redirect while halted loads the PC and flushes the queue, and the block stays HALTED.
- FAULT exists only with the Configuration macro. In FAULT, fetch is stopped and the queue is empty. An aligned redirect returns the block to RUN.

## Timing
- Reset values: `imem_addr` = `RESET_PC`, `id_valid`=0, `id_instr`=0, `id_pc`=0, `fault`=0, queue empty.
- First rising edge after `rst_n` deasserts: push from `RESET_PC`. `id_valid`=1 from the following cycle.
- Redirect sampled at edge N: `imem_addr` = target after N. Push at edge N+1. `id_valid` rises after N+1, a 2-cycle redirect-to-valid latency.
- Throughput is 1 instruction/cycle with `id_ready` held high.
- With `id_ready` low, the queue fills in QDEPTH cycles. Fetch PC then holds and `imem_addr` stays stable.
- Reset asserted mid-operation: immediate return to the reset values, and queue contents are discarded.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the queue and enters FAULT.
  - `fault`=1 from the next cycle until an aligned redirect. That redirect clears `fault` on the same edge.
- Not defined:
  - `redirect_pc[1:0]` is forced to 00 and the FAULT state is not built.
  - `fault` is tied 0.

## Structure
- Package `ifetch_pkg`:
  - width constants.
  - PC increment constant (4).
  - state enum {RUN, HALTED, FAULT}.
  - queue entry struct {pc, instr}.
- Sub-module `ifetch_queue`: a QDEPTH FIFO with push, pop, flush, and full/empty outputs. Flush has priority over push and pop.

## Test plan
- Memory bytes 0..7 = 12 34 56 78 9A BC DE F0, `id_ready`=1 after reset → (`id_pc`,`id_instr`) = (0x00, 0x12345678), then (0x04, 0x9ABCDEF0) on consecutive cycles.
- `id_ready`=0 for 5 cycles → queue full after 2 pushes, `imem_addr` holds at 0x08. Release `id_ready` → heads 0x00, 0x04, 0x08 in order, with no gap.
- Redirect to 0x40 while the queue holds 2 entries → next valid head has `id_pc`=0x40 exactly 2 cycles later. Stale entries never appear.
- Redirect to 0xFC → `id_pc` sequence 0xFC, 0x00, 0x04 (wrap). Instruction at 0xFC = bytes 252..255, big-endian.
- `halt` high for 4 cycles with a full queue and `id_ready`=1 → 2 entries drain, then `id_valid`=0 and `imem_addr` is frozen. Deassert `halt` → fetch resumes at the frozen address.
- Macro defined, redirect to 0x42 → `fault`=1 and `id_valid`=0. Redirect to 0x44 → `fault`=0 and the next head has `id_pc`=0x44. Macro undefined: the same stimulus gives `id_pc`=0x40 and `fault` stays 0.
